// File: rtl/regfile_1w2r_tracked.sv
// Register file with one write port and two registered read ports.
// A per-entry written bit flags reads of never-written or out-of-range entries as errors.
module regfile_1w2r_tracked #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = $clog2(DEPTH),
   parameter int unsigned BYPASS = 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr,
   input  logic              rd0_en,
   input  logic [ADDR_W-1:0] rd0_addr,
   output logic [DATA_W-1:0] rd0_data,
   output logic              rd0_valid,
   output logic              rd0_err,
   input  logic              rd1_en,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic [DATA_W-1:0] rd1_data,
   output logic              rd1_valid,
   output logic              rd1_err,
   output logic              wr_err,
   output logic [CNT_W-1:0]  valid_cnt
);

   // One extra bit so addresses at or above a non-power-of-2 DEPTH compare correctly.
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  written_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_in_range, wr_ok, wr_err_d, wr_err_q;

   logic              rd_en_v   [2];
   logic [ADDR_W-1:0] rd_addr_v [2];
   logic [DATA_W-1:0] rd_data_d [2];
   logic [DATA_W-1:0] rd_data_q [2];
   logic [1:0]        rd_err_d, rd_err_q, rd_valid_q;

   assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
   assign wr_ok       = wr_en & ~clr & wr_in_range;
   assign wr_err_d    = wr_en & ~wr_ok;

   assign rd_en_v[0]   = rd0_en;
   assign rd_en_v[1]   = rd1_en;
   assign rd_addr_v[0] = rd0_addr;
   assign rd_addr_v[1] = rd1_addr;

   // Lookups use pre-edge state, so a read alongside clr still sees the old contents.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data_d[p] = '0;
         rd_err_d[p]  = 1'b0;
         if (rd_en_v[p]) begin
            if (BYPASS != 0 && wr_ok && wr_addr == rd_addr_v[p]) begin
               rd_data_d[p] = wr_data;
            end else if ({1'b0, rd_addr_v[p]} < DEPTH_L && written_q[rd_addr_v[p]]) begin
               rd_data_d[p] = mem_q[rd_addr_v[p]];
            end else begin
               rd_err_d[p] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (wr_ok && !written_q[wr_addr]) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_ok) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         written_q <= '0;
         cnt_q     <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (clr) begin
            written_q <= '0;
         end else if (wr_ok) begin
            written_q[wr_addr] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_data_q[0] <= '0;
         rd_data_q[1] <= '0;
         rd_err_q     <= '0;
         rd_valid_q   <= '0;
         wr_err_q     <= 1'b0;
      end else begin
         rd_data_q[0] <= rd_data_d[0];
         rd_data_q[1] <= rd_data_d[1];
         rd_err_q     <= rd_err_d;
         rd_valid_q   <= {rd1_en, rd0_en};
         wr_err_q     <= wr_err_d;
      end
   end

   assign rd0_data  = rd_data_q[0];
   assign rd0_err   = rd_err_q[0];
   assign rd0_valid = rd_valid_q[0];
   assign rd1_data  = rd_data_q[1];
   assign rd1_err   = rd_err_q[1];
   assign rd1_valid = rd_valid_q[1];
   assign wr_err    = wr_err_q;
   assign valid_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_1w2r_tracked.sv
// Scoreboard bench for regfile_1w2r_tracked: three instances (bypass, no bypass, DEPTH=6).
// Expected read results are queued at issue and consumed by a monitor on rdN_valid.
module tb_regfile_1w2r_tracked;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetn;
   logic       wr_en     [3];
   logic [2:0] wr_addr   [3];
   logic [7:0] wr_data   [3];
   logic       clr       [3];
   logic       rd_en     [3][2];
   logic [2:0] rd_addr   [3][2];
   logic [7:0] rd_data   [3][2];
   logic       rd_valid  [3][2];
   logic       rd_err    [3][2];
   logic       wr_err    [3];
   logic [3:0] cnt_b1, cnt_b0;
   logic [2:0] cnt_d6;

   exp_t sb [6][$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   regfile_1w2r_tracked #(.DATA_W(8), .DEPTH(8), .BYPASS(1)) u_b1 (
      .clk(clk), .resetn(resetn),
      .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .clr(clr[0]),
      .rd0_en(rd_en[0][0]), .rd0_addr(rd_addr[0][0]), .rd0_data(rd_data[0][0]),
      .rd0_valid(rd_valid[0][0]), .rd0_err(rd_err[0][0]),
      .rd1_en(rd_en[0][1]), .rd1_addr(rd_addr[0][1]), .rd1_data(rd_data[0][1]),
      .rd1_valid(rd_valid[0][1]), .rd1_err(rd_err[0][1]),
      .wr_err(wr_err[0]), .valid_cnt(cnt_b1)
   );

   regfile_1w2r_tracked #(.DATA_W(8), .DEPTH(8), .BYPASS(0)) u_b0 (
      .clk(clk), .resetn(resetn),
      .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .clr(clr[1]),
      .rd0_en(rd_en[1][0]), .rd0_addr(rd_addr[1][0]), .rd0_data(rd_data[1][0]),
      .rd0_valid(rd_valid[1][0]), .rd0_err(rd_err[1][0]),
      .rd1_en(rd_en[1][1]), .rd1_addr(rd_addr[1][1]), .rd1_data(rd_data[1][1]),
      .rd1_valid(rd_valid[1][1]), .rd1_err(rd_err[1][1]),
      .wr_err(wr_err[1]), .valid_cnt(cnt_b0)
   );

   regfile_1w2r_tracked #(.DATA_W(8), .DEPTH(6), .BYPASS(1)) u_d6 (
      .clk(clk), .resetn(resetn),
      .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]), .clr(clr[2]),
      .rd0_en(rd_en[2][0]), .rd0_addr(rd_addr[2][0]), .rd0_data(rd_data[2][0]),
      .rd0_valid(rd_valid[2][0]), .rd0_err(rd_err[2][0]),
      .rd1_en(rd_en[2][1]), .rd1_addr(rd_addr[2][1]), .rd1_data(rd_data[2][1]),
      .rd1_valid(rd_valid[2][1]), .rd1_err(rd_err[2][1]),
      .wr_err(wr_err[2]), .valid_cnt(cnt_d6)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic idle();
      for (int d = 0; d < 3; d++) begin
         wr_en[d]   = 1'b0;
         wr_addr[d] = '0;
         wr_data[d] = '0;
         clr[d]     = 1'b0;
         for (int p = 0; p < 2; p++) begin
            rd_en[d][p]   = 1'b0;
            rd_addr[d][p] = '0;
         end
      end
   endtask

   task automatic wr(input int d, input logic [2:0] a, input logic [7:0] v);
      wr_en[d]   = 1'b1;
      wr_addr[d] = a;
      wr_data[d] = v;
   endtask

   task automatic rd(input int d, input int p, input logic [2:0] a,
                     input logic [7:0] ed, input logic ee);
      exp_t e;
      rd_en[d][p]   = 1'b1;
      rd_addr[d][p] = a;
      e.err  = ee;
      e.data = ed;
      sb[d*2+p].push_back(e);
   endtask

   // Inputs applied here are sampled by the next edge; outputs are then checked 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   // Monitor: pops one expectation per valid result; idle ports must present zeros.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 3; d++) begin
         for (int p = 0; p < 2; p++) begin
            if (rd_valid[d][p]) begin
               if (sb[d*2+p].size() == 0) begin
                  chk($sformatf("unexpected_valid_d%0d_p%0d", d, p), 1, 0);
               end else begin
                  e = sb[d*2+p].pop_front();
                  chk($sformatf("rd_data_d%0d_p%0d", d, p), 32'(rd_data[d][p]), 32'(e.data));
                  chk($sformatf("rd_err_d%0d_p%0d", d, p), 32'(rd_err[d][p]), 32'(e.err));
               end
            end else begin
               chk($sformatf("idle_zero_d%0d_p%0d", d, p),
                   {23'd0, rd_err[d][p], rd_data[d][p]}, 0);
            end
         end
      end
   end

   initial begin
      resetn = 1'b0;
      idle();
      #2;
      chk("reset_cnt_b1", 32'(cnt_b1), 0);
      chk("reset_wr_err", 32'(wr_err[0]), 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      // Reads straight after reset: unwritten entries.
      rd(0, 0, 3, 8'h00, 1'b1);
      rd(0, 1, 3, 8'h00, 1'b1);
      step();
      chk("cnt_after_reset", 32'(cnt_b1), 0);

      // Basic writes, dual read, rewrite does not count.
      wr(0, 2, 8'hA5);
      step();
      wr(0, 7, 8'h3C);
      step();
      rd(0, 0, 2, 8'hA5, 1'b0);
      rd(0, 1, 7, 8'h3C, 1'b0);
      step();
      chk("cnt_two", 32'(cnt_b1), 2);
      wr(0, 2, 8'h11);
      step();
      chk("cnt_rewrite", 32'(cnt_b1), 2);
      rd(0, 0, 2, 8'h11, 1'b0);
      step();

      // Same-address read/write collision, with and without bypass.
      wr(0, 5, 8'h5A);
      rd(0, 0, 5, 8'h5A, 1'b0);
      wr(1, 5, 8'h5A);
      rd(1, 0, 5, 8'h00, 1'b1);
      step();
      chk("cnt_b1_bypass", 32'(cnt_b1), 3);
      chk("cnt_b0_one", 32'(cnt_b0), 1);
      rd(1, 0, 5, 8'h5A, 1'b0);
      wr(0, 6, 8'h77);
      rd(0, 0, 6, 8'h77, 1'b0);
      rd(0, 1, 6, 8'h77, 1'b0);
      step();
      chk("cnt_b1_four", 32'(cnt_b1), 4);

      // Non-power-of-2 depth: out-of-range write and read.
      wr(2, 6, 8'h99);
      step();
      chk("d6_wr_err_pulse", 32'(wr_err[2]), 1);
      chk("d6_cnt_unchanged", 32'(cnt_d6), 0);
      rd(2, 0, 7, 8'h00, 1'b1);
      wr(2, 1, 8'h42);
      step();
      chk("d6_wr_err_cleared", 32'(wr_err[2]), 0);
      chk("d6_cnt_one", 32'(cnt_d6), 1);
      rd(2, 1, 1, 8'h42, 1'b0);
      wr(2, 5, 8'hC3);
      rd(2, 0, 5, 8'hC3, 1'b0);
      step();
      chk("d6_cnt_two", 32'(cnt_d6), 2);

      // Fill every entry, check saturation at DEPTH, then clr with colliding write/read.
      for (int i = 0; i < 8; i++) begin
         wr(0, 3'(i), 8'(8'h10 + i));
         step();
      end
      chk("cnt_full", 32'(cnt_b1), 8);
      wr(0, 3, 8'h13);
      step();
      chk("cnt_full_rewrite", 32'(cnt_b1), 8);
      clr[0] = 1'b1;
      wr(0, 0, 8'hEE);
      rd(0, 0, 4, 8'h14, 1'b0);
      rd(0, 1, 0, 8'h10, 1'b0);
      step();
      chk("clr_wr_err", 32'(wr_err[0]), 1);
      chk("clr_cnt", 32'(cnt_b1), 0);
      rd(0, 0, 0, 8'h00, 1'b1);
      step();
      chk("clr_wr_err_cleared", 32'(wr_err[0]), 0);

      // Asynchronous reset in the middle of a valid read cycle.
      wr(0, 4, 8'h66);
      step();
      rd(0, 0, 4, 8'h66, 1'b0);
      step();
      chk("pre_reset_valid", 32'(rd_valid[0][0]), 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("async_valid", 32'(rd_valid[0][0]), 0);
      chk("async_data", 32'(rd_data[0][0]), 0);
      chk("async_cnt_b1", 32'(cnt_b1), 0);
      chk("async_cnt_b0", 32'(cnt_b0), 0);
      chk("async_cnt_d6", 32'(cnt_d6), 0);
      // The in-flight result is discarded by reset.
      for (int i = 0; i < 6; i++) sb[i].delete();
      @(negedge clk);
      resetn = 1'b1;
      rd(0, 0, 4, 8'h00, 1'b1);
      rd(0, 1, 2, 8'h00, 1'b1);
      rd(1, 0, 5, 8'h00, 1'b1);
      rd(2, 1, 1, 8'h00, 1'b1);
      step();
      step();
      step();

      for (int i = 0; i < 6; i++) begin
         chk($sformatf("sb_drained_%0d", i), 32'(sb[i].size()), 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_1w2r_tracked.md
Name: regfile_1w2r_tracked

Overview:
- Parametrised register file with 1 write port and 2 independent read ports.
- Tracks a per-entry "written" bit, so a read of a never-written or out-of-range entry is flagged as an error instead of returning stale data.
- Adds single-cycle bulk clear, configurable write-to-read bypass, and a live count of occupied entries.
- Used as scratch/config storage in datapath blocks that need two operands per cycle.

Parameters:
- DATA_W, 8: width of each entry in bits (>=1).
- DEPTH, 8: number of entries (>=2, need not be a power of 2).
- ADDR_W, $clog2(DEPTH): address width.
- BYPASS, 1: 1 = write-first forwarding on same-address read/write; 0 = read returns pre-write contents.

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- clr  in  1  invalidate all entries.
- rd0_en  in  1  port 0 read request.
- rd0_addr  in  ADDR_W  port 0 read address.
- rd0_data  out  DATA_W  port 0 read data.
- rd0_valid  out  1  port 0 result valid.
- rd0_err  out  1  port 0 read error.
- rd1_en, rd1_addr, rd1_data, rd1_valid, rd1_err: same as port 0, for port 1.
- wr_err  out  1  write rejected (1-cycle pulse).
- valid_cnt  out  $clog2(DEPTH+1)  number of written entries.

Behaviour:
- Reset (resetn=0, asynchronous):
  - All outputs go to 0 immediately.
  - All written bits and storage entries go to 0.
  - Deassertion is sampled on the next rising edge.
- Write:
  - Accepted when wr_en=1, clr=0 and wr_addr<DEPTH.
  - An accepted write updates mem[wr_addr] and sets written[wr_addr] at the edge.
  - valid_cnt increments by 1 only if the entry was previously unwritten. Rewriting an entry leaves the count unchanged.
- wr_err = 1 for exactly one cycle after a rejected write (wr_en=1 with wr_addr>=DEPTH or clr=1). Otherwise wr_err = 0. Storage and count are unchanged on a rejected write.
- clr:
  - At the edge, clears all written bits and sets valid_cnt to 0.
  - Storage data need not be cleared. Entries read as 0 anyway because they are unwritten.
  - clr has priority over wr_en.
- Read, each port independent, registered, latency 1:
  - rdN_en=1 in cycle T makes rdN_valid=1 in cycle T+1, regardless of error.
  - rdN_en=0 in cycle T makes rdN_valid=0, rdN_data=0 and rdN_err=0 in cycle T+1.
  - Address >= DEPTH: rdN_data=0, rdN_err=1.
  - Entry unwritten: rdN_data=0, rdN_err=1.
  - Otherwise: rdN_data=mem[addr], rdN_err=0.
- Read state is sampled before the same edge's clr. A read in the same cycle as clr returns pre-clear contents and error status.
- Same-address read and accepted write in the same cycle:
  - BYPASS=1: rdN_data=wr_data, rdN_err=0, even if the entry was unwritten.
  - BYPASS=0: returns the old contents/error status. The new data is visible from the next read onward.
- Both read ports may target the same address, and either may collide with the write. Each port resolves independently.
- valid_cnt never exceeds DEPTH and never wraps.
- No combinational path from any input to any output.

Test Plan:
- After reset, read addr 3 on both ports -> next cycle rd0_valid=rd1_valid=1, data=0, err=1; valid_cnt=0.
- Write 0xA5 to addr 2, then 0x3C to addr 7, then rd0 addr 2 and rd1 addr 7 in the same cycle -> rd0_data=0xA5, rd1_data=0x3C, both err=0; valid_cnt=2. Rewrite addr 2 with 0x11 -> valid_cnt stays 2.
- Same cycle: wr addr 5 = 0x5A and rd0 addr 5 (entry unwritten):
  - BYPASS=1 -> rd0_data=0x5A, err=0.
  - BYPASS=0 -> rd0_data=0, err=1, and a read next cycle returns 0x5A.
- DEPTH=6: write to addr 6 -> wr_err=1 for one cycle, valid_cnt unchanged; read addr 7 -> data=0, err=1.
- Fill all 8 entries (valid_cnt=8), then assert clr together with wr_en to addr 0 and rd0 addr 4:
  - rd0 returns the pre-clear data with err=0.
  - wr_err=1 for one cycle.
  - valid_cnt=0.
  - A following read of addr 0 gives err=1.
- Assert resetn=0 mid-cycle while rd0_valid=1 -> all outputs drop to 0 before the next edge. After release, all entries read err=1.
